register_bank: RTL and testbench

//  - Register file in the execute datapath. Two asynchronous read ports drive the ALU operand inputs (data1, data2).
//  - One synchronous write port takes the ALU result (aluOut) or other writeback data from the control unit mux.
//  - A status flag register captures the ALU zero output for conditional branches.
//  - Single-cycle core: the ALU combinationally consumes this block's outputs and produces its next write data.

---
 rtl/bbtron_pkg.sv | 18 +
 rtl/register_bank.sv | 67 ++++++
 tb/tb_register_bank.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bbtron_pkg.sv
// Shared datapath constants for the bbtron core: default widths, the hardwired-zero
// register address, and the ALU operation encodings the control unit drives.
package bbtron_pkg;

   localparam int BB_DATA_W = 32;
   localparam int BB_ADDR_W = 5;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_SUB = 4'b0010,
      ALU_ADD = 4'b0011,
      ALU_SLT = 4'b0100
   } cu_aluop_e;

endpackage

// File: rtl/register_bank.sv
// Register file: two ALU operand read ports, one debug read port, one write port, zero flag.
// Latency: reads combinational (pre-edge state, no write bypass); writes and flag land on the clock edge.
// Backpressure: none; a write is accepted on every edge with cu_regWrite=1.
module register_bank #(
   parameter int DATA_W   = bbtron_pkg::BB_DATA_W,
   parameter int ADDR_W   = bbtron_pkg::BB_ADDR_W,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              cu_regWrite,
   input  logic [DATA_W-1:0] writeData,
   input  logic              cu_flagWrite,
   input  logic              alu_zero,
   output logic [DATA_W-1:0] data1,
   output logic [DATA_W-1:0] data2,
   output logic              flag_zero,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);
   import bbtron_pkg::*;

   localparam int NUM_REGS = 2 ** ADDR_W;
   localparam int NUM_RD   = 3;

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [ADDR_W-1:0] rd_port_addr [NUM_RD];
   logic [DATA_W-1:0] rd_port_data [NUM_RD];
   logic              wr_en;

   // Register 0 is never written when hardwired, so it can never hold a nonzero value.
   assign wr_en = cu_regWrite && !(ZERO_REG && (rd_addr == ADDR_W'(REG_ZERO)));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         flag_zero <= 1'b0;
      end else begin
         if (wr_en) begin
            regs[rd_addr] <= writeData;
         end
         if (cu_flagWrite) begin
            flag_zero <= alu_zero;
         end
      end
   end

   assign rd_port_addr[0] = rs_addr;
   assign rd_port_addr[1] = rt_addr;
   assign rd_port_addr[2] = dbg_addr;

   // Reads see storage only, never writeData, so data1 -> ALU -> writeData cannot loop.
   for (genvar p = 0; p < NUM_RD; p++) begin : g_read
      assign rd_port_data[p] = (ZERO_REG && (rd_port_addr[p] == ADDR_W'(REG_ZERO)))
                               ? '0 : regs[rd_port_addr[p]];
   end

   assign data1    = rd_port_data[0];
   assign data2    = rd_port_data[1];
   assign dbg_data = rd_port_data[2];

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench: ZERO_REG=1 and ZERO_REG=0 builds side by side, reference-array scoreboard.
module tb_register_bank;
   import bbtron_pkg::*;

   localparam int DW = BB_DATA_W;
   localparam int AW = BB_ADDR_W;
   localparam int NR = 2 ** AW;

   logic          clock = 1'b0;
   logic          reset_n;
   logic [AW-1:0] rs_addr, rt_addr, rd_addr, dbg_addr;
   logic          cu_regWrite, cu_flagWrite, alu_zero;
   logic [DW-1:0] writeData;

   logic [DW-1:0] z_d1, z_d2, z_dbg, n_d1, n_d2, n_dbg;
   logic          z_fz, n_fz;

   always #5 clock = ~clock;

   register_bank #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1)) u_z (
      .clock(clock), .reset_n(reset_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rd_addr(rd_addr), .cu_regWrite(cu_regWrite), .writeData(writeData),
      .cu_flagWrite(cu_flagWrite), .alu_zero(alu_zero), .data1(z_d1), .data2(z_d2),
      .flag_zero(z_fz), .dbg_addr(dbg_addr), .dbg_data(z_dbg)
   );

   register_bank #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0)) u_n (
      .clock(clock), .reset_n(reset_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rd_addr(rd_addr), .cu_regWrite(cu_regWrite), .writeData(writeData),
      .cu_flagWrite(cu_flagWrite), .alu_zero(alu_zero), .data1(n_d1), .data2(n_d2),
      .flag_zero(n_fz), .dbg_addr(dbg_addr), .dbg_data(n_dbg)
   );

   typedef struct {
      string         tag;
      logic [DW-1:0] val;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] mz [NR];
   logic [DW-1:0] mn [NR];
   logic          mf;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rdz(input logic [AW-1:0] a);
      return (a == '0) ? '0 : mz[a];
   endfunction

   function automatic logic [DW-1:0] alu(input cu_aluop_e op, input logic [DW-1:0] a,
                                         input logic [DW-1:0] b);
      case (op)
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_SUB: return a - b;
         ALU_ADD: return a + b;
         default: return {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NR; i++) begin
         mz[i] = '0;
         mn[i] = '0;
      end
      mf = 1'b0;
   endtask

   // Expected read values come from the model state before the coming edge.
   task automatic push_exp();
      sb.push_back('{"z_data1", rdz(rs_addr)});
      sb.push_back('{"z_data2", rdz(rt_addr)});
      sb.push_back('{"z_dbg",   rdz(dbg_addr)});
      sb.push_back('{"z_flag",  {{(DW-1){1'b0}}, mf}});
      sb.push_back('{"n_data1", mn[rs_addr]});
      sb.push_back('{"n_data2", mn[rt_addr]});
      sb.push_back('{"n_dbg",   mn[dbg_addr]});
      sb.push_back('{"n_flag",  {{(DW-1){1'b0}}, mf}});
   endtask

   task automatic compare_out();
      logic [DW-1:0] obs [8];
      exp_t          e;
      obs[0] = z_d1;  obs[1] = z_d2;  obs[2] = z_dbg;  obs[3] = {{(DW-1){1'b0}}, z_fz};
      obs[4] = n_d1;  obs[5] = n_d2;  obs[6] = n_dbg;  obs[7] = {{(DW-1){1'b0}}, n_fz};
      for (int i = 0; i < 8; i++) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=%0d", 0, 8 - i);
            return;
         end
         e = sb.pop_front();
         chk(e.tag, obs[i], e.val);
      end
   endtask

   // Called just after a falling edge with inputs already driven; returns after the next falling edge.
   task automatic cycle();
      push_exp();
      #1;
      compare_out();
      if (reset_n) begin
         if (cu_regWrite) begin
            if (rd_addr != '0) mz[rd_addr] = writeData;
            mn[rd_addr] = writeData;
         end
         if (cu_flagWrite) mf = alu_zero;
      end
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic drive(input logic we, input logic [AW-1:0] rd, input logic [DW-1:0] wd,
                        input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] dbg);
      cu_regWrite  = we;
      rd_addr      = rd;
      writeData    = wd;
      rs_addr      = rs;
      rt_addr      = rt;
      dbg_addr     = dbg;
      cu_flagWrite = 1'b0;
      alu_zero     = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] alu_out;

      reset_n = 1'b0;
      drive(1'b0, '0, '0, 5'd1, 5'd2, 5'd3);
      model_reset();
      #1;
      chk("por_data1", z_d1, '0);
      chk("por_flag", {{(DW-1){1'b0}}, z_fz}, '0);
      @(negedge clock);
      reset_n = 1'b1;

      // Populate a few registers and the flag, then reset asynchronously mid-cycle.
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, AW'(i), DW'(32'h11 * i), AW'(i - 1), AW'(i), 5'd3);
         cu_flagWrite = 1'b1;
         alu_zero     = 1'b1;
         cycle();
      end
      drive(1'b0, '0, '0, 5'd1, 5'd2, 5'd3);
      #1;
      chk("pre_rst_data1", n_d1, 32'h11);
      chk("pre_rst_flag", {{(DW-1){1'b0}}, n_fz}, 32'd1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("rst_z_data1", z_d1, '0);
      chk("rst_z_data2", z_d2, '0);
      chk("rst_z_dbg", z_dbg, '0);
      chk("rst_n_data1", n_d1, '0);
      chk("rst_n_data2", n_d2, '0);
      chk("rst_n_dbg", n_dbg, '0);
      chk("rst_flag", {{(DW-1){1'b0}}, z_fz}, '0);
      model_reset();
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;

      // Write r3 while reading it: old value this cycle, new value after the edge.
      drive(1'b1, 5'd3, 32'h0000_00A5, 5'd3, 5'd3, 5'd3);
      #1;
      chk("wr_cycle_data1", z_d1, '0);
      chk("wr_cycle_data2", z_d2, '0);
      cycle();
      drive(1'b0, '0, '0, 5'd3, 5'd3, 5'd3);
      #1;
      chk("after_wr_data1", z_d1, 32'h0000_00A5);
      chk("after_wr_data2", z_d2, 32'h0000_00A5);
      cycle();

      // Hardwired zero register versus ordinary register 0.
      drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
      cycle();
      drive(1'b0, '0, '0, 5'd0, 5'd0, 5'd0);
      #1;
      chk("zero_reg_data1", z_d1, '0);
      chk("plain_r0_data1", n_d1, 32'hFFFF_FFFF);
      cycle();

      // r31=7, r1=5, subtract through the bench ALU, write back to r2.
      drive(1'b1, 5'd31, 32'd7, 5'd0, 5'd0, 5'd0);
      cycle();
      drive(1'b1, 5'd1, 32'd5, 5'd31, 5'd1, 5'd0);
      cycle();
      drive(1'b0, '0, '0, 5'd31, 5'd1, 5'd2);
      #1;
      chk("alu_in_data1", z_d1, 32'd7);
      chk("alu_in_data2", z_d2, 32'd5);
      alu_out = alu(ALU_SUB, z_d1, z_d2);
      drive(1'b1, 5'd2, alu_out, 5'd31, 5'd1, 5'd2);
      cycle();
      drive(1'b0, '0, '0, 5'd31, 5'd1, 5'd2);
      #1;
      chk("writeback_dbg", z_dbg, 32'd2);
      cycle();

      // Flag capture then hold.
      drive(1'b0, '0, '0, 5'd0, 5'd0, 5'd0);
      cu_flagWrite = 1'b1;
      alu_zero     = 1'b1;
      cycle();
      drive(1'b0, '0, '0, 5'd0, 5'd0, 5'd0);
      #1;
      chk("flag_set", {{(DW-1){1'b0}}, z_fz}, 32'd1);
      cycle();
      chk("flag_hold", {{(DW-1){1'b0}}, z_fz}, 32'd1);

      // Disabled write must not touch r4; same-address read/write both ports.
      drive(1'b0, 5'd4, 32'h0000_1234, 5'd4, 5'd4, 5'd4);
      cycle();
      drive(1'b0, '0, '0, 5'd4, 5'd4, 5'd4);
      #1;
      chk("no_write_r4", z_dbg, '0);
      drive(1'b1, 5'd9, 32'hDEAD_BEEF, 5'd9, 5'd9, 5'd9);
      cycle();
      drive(1'b0, '0, '0, 5'd9, 5'd9, 5'd9);
      #1;
      chk("same_addr_data1", z_d1, 32'hDEAD_BEEF);
      chk("same_addr_data2", n_d2, 32'hDEAD_BEEF);
      cycle();

      // Random traffic against the reference arrays.
      for (int n = 0; n < 10000; n++) begin
         logic [AW-1:0] a;
         a = AW'($urandom_range(0, NR - 1));
         drive(1'($urandom_range(0, 1)), a, DW'($urandom),
               ($urandom_range(0, 3) == 0) ? a : AW'($urandom_range(0, NR - 1)),
               ($urandom_range(0, 3) == 0) ? a : AW'($urandom_range(0, NR - 1)),
               AW'($urandom_range(0, NR - 1)));
         cu_flagWrite = 1'($urandom_range(0, 1));
         alu_zero     = 1'($urandom_range(0, 1));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
